trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter XLEN, default 64, datapath width of captured PC and write-data.
REQ-002 Parameter DEPTH, default 16, trace buffer entries; power of two, >= 2.
REQ-003 Parameter POST_TRIG, default 4, entries captured after the trigger entry; range 0..DEPTH-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 arm  input  1  single-cycle pulse that clears the buffer and starts capture.
REQ-007 stop  input  1  manual stop / manual trigger.
REQ-008 mode  input  2  trigger mode, sampled on arm: 0 free-run, 1 PC match, 2 register-write match, 3 manual trigger.
REQ-009 trig_pc  input  XLEN  PC compare value for mode 1.
REQ-010 trig_rd  input  5  destination-register compare value for mode 2.
REQ-011 cap_valid  input  1  instruction-retire strobe; one entry per asserted cycle.
REQ-012 cap_pc  input  XLEN, cap_instr  input  32, cap_regwrite  input  1, cap_rd  input  5, cap_wdata  input  XLEN: retire fields.
REQ-013 rd_idx  input  $clog2(DEPTH)  readout index, 0 = oldest.
REQ-014 rd_pc  output  XLEN, rd_instr  output  32, rd_regwrite  output  1, rd_rd  output  5, rd_wdata  output  XLEN: entry at rd_idx.
REQ-015 state  output  2, count  output  $clog2(DEPTH)+1, triggered  output  1, done  output  1.

Function
REQ-016 States: IDLE (0), ARMED (1), POST (2), DONE (3).
REQ-017 IDLE: no capture; arm -> ARMED.
REQ-018 arm in any state -> ARMED next cycle, with wr_ptr, count, triggered, done cleared and mode latched; arm wins over simultaneous stop or trigger.
REQ-019 ARMED/POST: cap_valid writes entry at wr_ptr; wr_ptr increments mod DEPTH; count saturates at DEPTH, oldest entry overwritten.
REQ-020 Trigger, ARMED only, evaluated on the current-cycle inputs: mode 1 cap_valid && cap_pc==trig_pc; mode 2 cap_valid && cap_regwrite && cap_rd==trig_rd && cap_rd!=0; mode 3 stop (cap_valid not required); mode 0 never.
REQ-021 The trigger entry, when cap_valid, is itself captured; triggered rises the following cycle and holds until arm or reset.
REQ-022 On trigger: POST_TRIG==0 -> DONE; otherwise -> POST with post counter loaded to POST_TRIG.
REQ-023 POST: each cap_valid captures and decrements the post counter; the entry that takes it to 0 is captured, then -> DONE.
REQ-024 stop in ARMED (modes 0-2) or in POST -> DONE next cycle; any same-cycle cap_valid entry is captured.
REQ-025 DONE: no capture; done=1; buffer contents frozen.
REQ-026 Readout combinational: physical index = (wr_ptr - count + rd_idx) mod DEPTH; rd_idx >= count -> all rd_* outputs zero.
REQ-027 mode/trig_* changes after arm have no effect except trig_* compare values, which are used live.

Reset
REQ-028 rst low -> state IDLE, wr_ptr 0, count 0, post counter 0, triggered 0, done 0, asynchronously, including mid-capture.
REQ-029 Buffer storage is not reset; count=0 masks all readout to zero.

Structure
REQ-030 Package trace_pkg holds the state enum, mode constants, and a parameterised-width entry struct typedef.
REQ-031 Sub-module trace_ram: DEPTH x entry, one synchronous write port, one asynchronous read port.

Verification (DEPTH=16, POST_TRIG=4)
REQ-032 Mode 1, trig_pc=0x40, retire PCs 0x00..0x50 step 4 -> done=1, count=16, rd_idx 0 pc=0x14, rd_idx 15 pc=0x50.
REQ-033 Mode 2, trig_rd=5: retire rd=0 regwrite -> no trigger; rd=5 wdata=0xDEAD -> triggered; 4 more retires -> DONE, entry (count-5) wdata=0xDEAD.
REQ-034 Mode 3: 3 retires, stop with cap_valid=0, 4 retires -> count=7, rd_idx 7 reads all zeros.
REQ-035 Mode 0: 40 retires, pc=N*4, then stop -> DONE, count=16, rd_idx 0 pc=0x60.
REQ-036 rst low during POST -> state=IDLE, count=0, done=0, triggered=0 within the same cycle.
REQ-037 arm and stop together in DONE -> state=ARMED, count=0, done=0.

Source files
------------

// File: rtl/trace_capture_pkg.sv
// Shared types for the instruction trace capture block: FSM states,
// trigger-mode encodings and the stored trace entry layout.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_FREE   = 2'd0;
    localparam logic [1:0] MODE_PC     = 2'd1;
    localparam logic [1:0] MODE_REG    = 2'd2;
    localparam logic [1:0] MODE_MANUAL = 2'd3;

    // Entries are stored at the widest supported XLEN; narrower cores zero-extend.
    localparam int XLEN_MAX = 64;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [31:0]         instr;
        logic                regwrite;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] wdata;
    } entry_t;

endpackage

// File: rtl/trace_capture_if.sv
// Control, retire and readout bundle of the trace capture block.
interface trace_capture_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic            arm;
    logic            stop;
    logic [1:0]      mode;
    logic [XLEN-1:0] trig_pc;
    logic [4:0]      trig_rd;
    logic            cap_valid;
    logic [XLEN-1:0] cap_pc;
    logic [31:0]     cap_instr;
    logic            cap_regwrite;
    logic [4:0]      cap_rd;
    logic [XLEN-1:0] cap_wdata;
    logic [AW-1:0]   rd_idx;
    logic [XLEN-1:0] rd_pc;
    logic [31:0]     rd_instr;
    logic            rd_regwrite;
    logic [4:0]      rd_rd;
    logic [XLEN-1:0] rd_wdata;
    logic [1:0]      state;
    logic [AW:0]     count;
    logic            triggered;
    logic            done;

    modport master (
        output arm, stop, mode, trig_pc, trig_rd,
        output cap_valid, cap_pc, cap_instr, cap_regwrite, cap_rd, cap_wdata,
        output rd_idx,
        input  rd_pc, rd_instr, rd_regwrite, rd_rd, rd_wdata,
        input  state, count, triggered, done
    );

    modport slave (
        input  arm, stop, mode, trig_pc, trig_rd,
        input  cap_valid, cap_pc, cap_instr, cap_regwrite, cap_rd, cap_wdata,
        input  rd_idx,
        output rd_pc, rd_instr, rd_regwrite, rd_rd, rd_wdata,
        output state, count, triggered, done
    );

endinterface

// File: rtl/trace_capture_ram.sv
// Trace buffer storage: one synchronous write port, one asynchronous read port.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output entry_t        o_rdata
);

    entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trace_capture.sv
// Instruction-retire trace buffer with PC / register-write / manual triggers
// and a configurable number of post-trigger entries.
module trace_capture
    import trace_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic           clk,
    input  logic           rst,
    trace_capture_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);
    localparam bit            NO_POST   = (POST_TRIG == 0);

    state_e        r_state, w_state_nx;
    logic [1:0]    r_mode, w_mode_nx;
    logic [AW-1:0] r_wr_ptr, w_ptr_nx;
    logic [CW-1:0] r_count, w_count_nx;
    logic [AW-1:0] r_post_cnt, w_post_nx;
    logic          r_triggered, w_trig_nx;
    logic          w_we;
    logic          w_hit;
    entry_t        w_wentry;
    entry_t        w_rentry;
    logic [AW-1:0] w_raddr;
    logic          w_rd_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_FREE;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_post_cnt  <= '0;
            r_triggered <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_mode      <= w_mode_nx;
            r_wr_ptr    <= w_ptr_nx;
            r_count     <= w_count_nx;
            r_post_cnt  <= w_post_nx;
            r_triggered <= w_trig_nx;
        end
    end

    // Trigger compare uses the latched mode but live compare values.
    always_comb begin
        w_hit = 1'b0;
        unique case (r_mode)
            MODE_PC:     w_hit = bus.cap_valid && (bus.cap_pc == bus.trig_pc);
            MODE_REG:    w_hit = bus.cap_valid && bus.cap_regwrite &&
                                 (bus.cap_rd == bus.trig_rd) && (bus.cap_rd != 5'd0);
            MODE_MANUAL: w_hit = bus.stop;
            default:     w_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_ptr_nx   = r_wr_ptr;
        w_count_nx = r_count;
        w_post_nx  = r_post_cnt;
        w_trig_nx  = r_triggered;
        w_we       = 1'b0;

        if (bus.arm) begin
            w_state_nx = ST_ARMED;
            w_mode_nx  = bus.mode;
            w_ptr_nx   = '0;
            w_count_nx = '0;
            w_post_nx  = '0;
            w_trig_nx  = 1'b0;
        end else begin
            w_we = bus.cap_valid && (r_state == ST_ARMED || r_state == ST_POST);
            if (w_we) begin
                w_ptr_nx = r_wr_ptr + AW'(1);
                if (r_count != FULL) begin
                    w_count_nx = r_count + CW'(1);
                end
            end

            unique case (r_state)
                ST_ARMED: begin
                    if (w_hit) begin
                        w_trig_nx = 1'b1;
                        if (NO_POST) begin
                            w_state_nx = ST_DONE;
                        end else begin
                            w_state_nx = ST_POST;
                            w_post_nx  = POST_LOAD;
                        end
                    end else if (bus.stop) begin
                        w_state_nx = ST_DONE;
                    end
                end
                ST_POST: begin
                    if (bus.cap_valid) begin
                        w_post_nx = r_post_cnt - AW'(1);
                    end
                    if (bus.stop || (bus.cap_valid && r_post_cnt == AW'(1))) begin
                        w_state_nx = ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_wentry          = '0;
        w_wentry.pc       = XLEN_MAX'(bus.cap_pc);
        w_wentry.instr    = bus.cap_instr;
        w_wentry.regwrite = bus.cap_regwrite;
        w_wentry.rd       = bus.cap_rd;
        w_wentry.wdata    = XLEN_MAX'(bus.cap_wdata);
    end

    trace_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wentry),
        .i_raddr (w_raddr),
        .o_rdata (w_rentry)
    );

    // Oldest entry sits count slots behind the write pointer.
    assign w_raddr = r_wr_ptr - r_count[AW-1:0] + bus.rd_idx;
    assign w_rd_ok = ({1'b0, bus.rd_idx} < r_count);

    assign bus.rd_pc       = w_rd_ok ? XLEN'(w_rentry.pc)    : '0;
    assign bus.rd_instr    = w_rd_ok ? w_rentry.instr        : '0;
    assign bus.rd_regwrite = w_rd_ok ? w_rentry.regwrite     : 1'b0;
    assign bus.rd_rd       = w_rd_ok ? w_rentry.rd           : '0;
    assign bus.rd_wdata    = w_rd_ok ? XLEN'(w_rentry.wdata) : '0;

    assign bus.state     = r_state;
    assign bus.count     = r_count;
    assign bus.triggered = r_triggered;
    assign bus.done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: vector table plus hand-written sequences.
module tb_trace_capture;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    trace_capture_if #(.XLEN(64), .DEPTH(16)) bus ();

    trace_capture #(
        .XLEN      (64),
        .DEPTH     (16),
        .POST_TRIG (4)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    typedef struct {
        logic        arm;
        logic        stop;
        logic [1:0]  mode;
        logic        cv;
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] wd;
        logic [3:0]  idx;
        logic [1:0]  st;
        logic [4:0]  cnt;
        logic        trg;
        logic [63:0] exp_wd;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.arm          = 1'b0;
        bus.stop         = 1'b0;
        bus.cap_valid    = 1'b0;
        bus.cap_regwrite = 1'b0;
        bus.cap_rd       = 5'd0;
        bus.cap_pc       = '0;
        bus.cap_wdata    = '0;
        bus.cap_instr    = '0;
    endtask

    task automatic retire(input logic [63:0] pc, input logic [63:0] wd);
        bus.cap_valid = 1'b1;
        bus.cap_pc    = pc;
        bus.cap_wdata = wd;
        bus.cap_instr = 32'h0000_0013;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_arm(input logic [1:0] m);
        bus.arm  = 1'b1;
        bus.mode = m;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        bus.mode    = 2'd0;
        bus.trig_pc = 64'h40;
        bus.trig_rd = 5'd5;
        bus.rd_idx  = 4'd0;

        //         arm   stp  mode  cv    rw    rd     wd        idx   st    cnt   trg   exp_wd
        vecs[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 5'd0, 64'h0,    4'd0, 2'd1, 5'd0, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd0, 64'h11,   4'd0, 2'd1, 5'd1, 1'b0, 64'h11};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd5, 64'h22,   4'd1, 2'd1, 5'd2, 1'b0, 64'h22};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd5, 64'hDEAD, 4'd2, 2'd2, 5'd3, 1'b1, 64'hDEAD};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd1, 64'h33,   4'd3, 2'd2, 5'd4, 1'b1, 64'h33};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd1, 64'h34,   4'd0, 2'd2, 5'd5, 1'b1, 64'h11};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd1, 64'h35,   4'd5, 2'd2, 5'd6, 1'b1, 64'h35};
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd1, 64'h36,   4'd6, 2'd3, 5'd7, 1'b1, 64'h36};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd1, 64'h99,   4'd2, 2'd3, 5'd7, 1'b1, 64'hDEAD};
        vecs[9]  = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 5'd0, 64'h0,    4'd0, 2'd1, 5'd0, 1'b0, 64'h0};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 64'hA0,   4'd0, 2'd1, 5'd1, 1'b0, 64'hA0};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 64'hA1,   4'd1, 2'd1, 5'd2, 1'b0, 64'hA1};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 64'hA2,   4'd2, 2'd1, 5'd3, 1'b0, 64'hA2};
        vecs[13] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0, 64'h0,    4'd3, 2'd2, 5'd3, 1'b1, 64'h0};
        vecs[14] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 64'hB0,   4'd3, 2'd2, 5'd4, 1'b1, 64'hB0};
        vecs[15] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 64'hB1,   4'd4, 2'd2, 5'd5, 1'b1, 64'hB1};
        vecs[16] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 64'hB2,   4'd0, 2'd2, 5'd6, 1'b1, 64'hA0};
        vecs[17] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 64'hB3,   4'd7, 2'd3, 5'd7, 1'b1, 64'h0};
        vecs[18] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0, 64'h0,    4'd0, 2'd1, 5'd0, 1'b0, 64'h0};
        vecs[19] = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 5'd0, 64'hC0,   4'd0, 2'd3, 5'd1, 1'b0, 64'hC0};

        // Reset state
        #12;
        chk("reset_state", 64'(bus.state), 64'd0);
        chk("reset_count", 64'(bus.count), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_trig", 64'(bus.triggered), 64'd0);
        chk("reset_rd_pc", bus.rd_pc, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven: mode 2 register-write trigger, mode 3 manual, stop handling
        for (int i = 0; i < 20; i++) begin
            bus.arm          = vecs[i].arm;
            bus.stop         = vecs[i].stop;
            if (vecs[i].arm) bus.mode = vecs[i].mode;
            bus.cap_valid    = vecs[i].cv;
            bus.cap_regwrite = vecs[i].rw;
            bus.cap_rd       = vecs[i].rd;
            bus.cap_wdata    = vecs[i].wd;
            bus.cap_pc       = 64'h100 + 64'(i);
            @(posedge clk);
            #1;
            clear_inputs();
            bus.mode   = 2'd0;
            bus.rd_idx = vecs[i].idx;
            #1;
            chk($sformatf("v%0d_state", i), 64'(bus.state), 64'(vecs[i].st));
            chk($sformatf("v%0d_count", i), 64'(bus.count), 64'(vecs[i].cnt));
            chk($sformatf("v%0d_trig", i), 64'(bus.triggered), 64'(vecs[i].trg));
            chk($sformatf("v%0d_done", i), 64'(bus.done), 64'(vecs[i].st == 2'd3));
            chk($sformatf("v%0d_rd_wdata", i), bus.rd_wdata, vecs[i].exp_wd);
        end

        // Mode 1 PC trigger with wrap: PCs 0x00..0x50
        bus.trig_pc = 64'h40;
        do_arm(2'd1);
        for (int i = 0; i <= 20; i++) begin
            retire(64'(i * 4), 64'(i));
            if (i == 15) chk("m1_pre_trig_state", 64'(bus.state), 64'd1);
            if (i == 16) chk("m1_post_state", 64'(bus.state), 64'd2);
        end
        chk("m1_done", 64'(bus.done), 64'd1);
        chk("m1_count", 64'(bus.count), 64'd16);
        chk("m1_trig", 64'(bus.triggered), 64'd1);
        bus.rd_idx = 4'd0;
        #1;
        chk("m1_rd0_pc", bus.rd_pc, 64'h14);
        bus.rd_idx = 4'd15;
        #1;
        chk("m1_rd15_pc", bus.rd_pc, 64'h50);
        retire(64'h54, 64'h0);
        chk("m1_frozen_pc", bus.rd_pc, 64'h50);

        // Mode 0 free-run, 40 retires, then manual stop
        do_arm(2'd0);
        for (int i = 0; i < 40; i++) retire(64'(i * 4), 64'(i));
        chk("m0_state_running", 64'(bus.state), 64'd1);
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        clear_inputs();
        chk("m0_state", 64'(bus.state), 64'd3);
        chk("m0_count", 64'(bus.count), 64'd16);
        chk("m0_trig", 64'(bus.triggered), 64'd0);
        bus.rd_idx = 4'd0;
        #1;
        chk("m0_rd0_pc", bus.rd_pc, 64'h60);
        bus.rd_idx = 4'd15;
        #1;
        chk("m0_rd15_pc", bus.rd_pc, 64'h9C);

        // Asynchronous reset while in POST
        do_arm(2'd3);
        retire(64'h200, 64'h1);
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        clear_inputs();
        retire(64'h204, 64'h2);
        chk("rst_pre_state", 64'(bus.state), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 64'(bus.state), 64'd0);
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_trig", 64'(bus.triggered), 64'd0);
        bus.rd_idx = 4'd0;
        #1;
        chk("arst_rd_pc", bus.rd_pc, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        retire(64'h300, 64'h3);
        chk("idle_no_capture", 64'(bus.count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
